// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: op encoding shared by the PC/stack unit and its bench
package pc_stack_pkg;
   localparam int OP_W = 3;
   typedef enum logic [OP_W-1:0] {
      OP_INC  = 3'd0,
      OP_LOAD = 3'd1,
      OP_REL  = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_e;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO with occupancy count; storage itself is not reset
module ret_stack #(
   parameter int ADDR_WIDTH  = 16,
   parameter int STACK_DEPTH = 8,
   localparam int DW = $clog2(STACK_DEPTH + 1),
   localparam int AW = $clog2(STACK_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] push_data,
   output logic [ADDR_WIDTH-1:0] top,
   output logic [DW-1:0]         depth,
   output logic                  full,
   output logic                  empty
);
   logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
   logic [ADDR_WIDTH-1:0] mem_d [STACK_DEPTH];
   logic [DW-1:0]         depth_q, depth_d;
   logic                  do_push, do_pop;

   assign full    = depth_q == DW'(STACK_DEPTH);
   assign empty   = depth_q == '0;
   assign depth   = depth_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign top     = empty ? '0 : mem_q[AW'(depth_q - DW'(1))];

   // write the next free slot on push, move the occupancy count
   always_comb begin
      mem_d   = mem_q;
      depth_d = do_push ? depth_q + DW'(1) : do_pop ? depth_q - DW'(1) : depth_q;
      if (do_push) mem_d[AW'(depth_q)] = push_data;
   end

   // only the occupancy needs reset; stale entries are unreachable when empty
   always_ff @(posedge clk) begin
      mem_q   <= mem_d;
      depth_q <= reset ? '0 : depth_d;
   end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with call/return stack; PC_STACK_TRAP_EN redirects stack faults to TRAP_VECTOR and adds the trap pulse
module pc_stack_unit
   import pc_stack_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int STACK_DEPTH  = 8,
   parameter int OFFSET_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = '1,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pc_en,
   input  logic [OP_W-1:0]         op,
   input  logic [ADDR_WIDTH-1:0]   target,
   input  logic [OFFSET_WIDTH-1:0] offset,
   output logic [ADDR_WIDTH-1:0]   pc_out,
   output logic [ADDR_WIDTH-1:0]   ret_top,
   output logic [DW-1:0]           depth,
   output logic                    full,
   output logic                    empty,
   output logic                    stack_err
`ifdef PC_STACK_TRAP_EN
   ,output logic                   trap
`endif
);
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, rel_ext;
   logic                  stack_err_q, stack_err_d;
   logic                  is_call, is_ret, fault;

   assign pc_inc    = pc_q + ADDR_WIDTH'(1);
   assign rel_ext   = ADDR_WIDTH'($signed(offset));
   assign is_call   = op == OP_CALL;
   assign is_ret    = op == OP_RET;
   assign fault     = pc_en && ((is_call && full) || (is_ret && empty));
   assign pc_out    = pc_q;
   assign stack_err = stack_err_q;

   ret_stack #(.ADDR_WIDTH(ADDR_WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (pc_en && is_call),
      .pop       (pc_en && is_ret),
      .push_data (pc_inc),
      .top       (ret_top),
      .depth     (depth),
      .full      (full),
      .empty     (empty)
   );

`ifdef PC_STACK_TRAP_EN
   logic trap_q, trap_d;
   assign trap = trap_q;
`endif

   // next PC per op; ops 5-7 fall through to increment, faults are sticky
   always_comb begin
      pc_d        = pc_q;
      stack_err_d = stack_err_q | fault;
      if (pc_en)
         pc_d = op == OP_LOAD ? target :
                op == OP_REL  ? pc_q + rel_ext :
                is_call       ? target :
                is_ret        ? (empty ? pc_inc : ret_top) : pc_inc;
`ifdef PC_STACK_TRAP_EN
      trap_d = fault;
      if (fault) pc_d = TRAP_VECTOR;
`endif
   end

   // state registers; reset overrides any op presented in the same cycle
   always_ff @(posedge clk) begin
      pc_q        <= reset ? RESET_VECTOR : pc_d;
      stack_err_q <= reset ? 1'b0 : stack_err_d;
`ifdef PC_STACK_TRAP_EN
      trap_q      <= reset ? 1'b0 : trap_d;
`endif
   end
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and random checks of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;
   import pc_stack_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pc_en = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] target = '0;
   logic [7:0]  offset = '0;
   logic [15:0] pc_out, ret_top;
   logic [3:0]  depth;
   logic        full, empty, stack_err;
   logic        trap;

   int n_vec = 0;
   int n_bad = 0;
   int n_step = 0;

   logic [15:0] m_pc = '0;
   logic [15:0] m_stk[$];
   bit          m_err = 1'b0;
   bit          m_trap = 1'b0;

   pc_stack_unit dut (
      .clk       (clk),
      .reset     (reset),
      .pc_en     (pc_en),
      .op        (op),
      .target    (target),
      .offset    (offset),
      .pc_out    (pc_out),
      .ret_top   (ret_top),
      .depth     (depth),
      .full      (full),
      .empty     (empty),
      .stack_err (stack_err)
`ifdef PC_STACK_TRAP_EN
      ,.trap     (trap)
`endif
   );
`ifndef PC_STACK_TRAP_EN
   assign trap = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s step %0d got %0h expected %0h", tag, n_step, got, exp);
      end
   endtask

   task automatic model(bit rs, bit en, logic [2:0] o, logic [15:0] t, logic [7:0] f);
      m_trap = 1'b0;
      if (rs) begin
         m_pc = '0;
         m_stk.delete();
         m_err = 1'b0;
      end else if (en) begin
         case (o)
            3'd1: m_pc = t;
            3'd2: m_pc = 16'(int'(m_pc) + int'($signed(f)));
            3'd3: if (m_stk.size() < 8) begin
                     m_stk.push_back(m_pc + 16'd1);
                     m_pc = t;
                  end else begin
                     m_err = 1'b1;
`ifdef PC_STACK_TRAP_EN
                     m_pc = 16'hFFFF;
                     m_trap = 1'b1;
`else
                     m_pc = t;
`endif
                  end
            3'd4: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                  else begin
                     m_err = 1'b1;
`ifdef PC_STACK_TRAP_EN
                     m_pc = 16'hFFFF;
                     m_trap = 1'b1;
`else
                     m_pc = m_pc + 16'd1;
`endif
                  end
            default: m_pc = m_pc + 16'd1;
         endcase
      end
   endtask

   task automatic check_all();
      chk("pc_out", 32'(pc_out), 32'(m_pc));
      chk("depth", 32'(depth), 32'(m_stk.size()));
      chk("ret_top", 32'(ret_top), m_stk.size() > 0 ? 32'(m_stk[$]) : 32'd0);
      chk("full", 32'(full), 32'(m_stk.size() == 8));
      chk("empty", 32'(empty), 32'(m_stk.size() == 0));
      chk("stack_err", 32'(stack_err), 32'(m_err));
      chk("trap", 32'(trap), 32'(m_trap));
   endtask

   task automatic step(bit rs, bit en, logic [2:0] o, logic [15:0] t, logic [7:0] f);
      reset = rs;
      pc_en = en;
      op = o;
      target = t;
      offset = f;
      @(posedge clk);
      #1;
      n_step++;
      model(rs, en, o, t, f);
      check_all();
   endtask

   initial begin
      step(1, 0, 3'd0, 16'h0, 8'h0);
      step(1, 1, 3'd3, 16'h1234, 8'h0);
      chk("reset_pc", 32'(pc_out), 32'h0);
      chk("reset_empty", 32'(empty), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, OP_INC, 16'h0, 8'h0);
         chk("inc_seq", 32'(pc_out), 32'(i));
      end
      step(0, 1, OP_LOAD, 16'h0010, 8'h0);
      step(0, 1, OP_CALL, 16'h0100, 8'h0);
      chk("call_pc", 32'(pc_out), 32'h0100);
      chk("call_top", 32'(ret_top), 32'h0011);
      step(0, 1, OP_RET, 16'h0, 8'h0);
      chk("ret_pc", 32'(pc_out), 32'h0011);
      chk("ret_depth", 32'(depth), 32'd0);
      step(0, 1, OP_LOAD, 16'hFFFF, 8'h0);
      step(0, 1, OP_INC, 16'h0, 8'h0);
      chk("inc_wrap", 32'(pc_out), 32'h0000);
      step(0, 1, OP_LOAD, 16'h0005, 8'h0);
      step(0, 1, OP_REL, 16'h0, 8'hFA);
      chk("rel_neg_wrap", 32'(pc_out), 32'hFFFF);
      step(0, 1, 3'd6, 16'h0, 8'h0);
      chk("op6_inc", 32'(pc_out), 32'h0000);
      for (int i = 0; i < 9; i++) begin
         step(0, 1, OP_CALL, 16'h1000 + 16'(i), 8'h0);
         if (i == 7) chk("full_after_8", 32'(full), 32'd1);
      end
      chk("ovf_depth", 32'(depth), 32'd8);
      chk("ovf_err", 32'(stack_err), 32'd1);
`ifdef PC_STACK_TRAP_EN
      chk("ovf_pc", 32'(pc_out), 32'hFFFF);
      step(0, 1, OP_INC, 16'h0, 8'h0);
      chk("trap_one_cycle", 32'(trap), 32'd0);
`else
      chk("ovf_pc", 32'(pc_out), 32'h1008);
`endif
      step(1, 0, OP_INC, 16'h0, 8'h0);
      step(0, 1, OP_RET, 16'h0, 8'h0);
      chk("unf_err", 32'(stack_err), 32'd1);
      for (int i = 0; i < 3; i++) step(0, 0, 3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom));
      chk("hold_err", 32'(stack_err), 32'd1);
      step(1, 0, OP_INC, 16'h0, 8'h0);
      chk("reset_clears_err", 32'(stack_err), 32'd0);
      step(0, 1, OP_LOAD, 16'h0200, 8'h0);
      step(1, 1, OP_CALL, 16'h0300, 8'h0);
      chk("rst_call_pc", 32'(pc_out), 32'h0);
      chk("rst_call_depth", 32'(depth), 32'd0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)),
              16'($urandom), 8'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
